// File: rtl/fetch_sequencer.sv
// PC/RA owner and single-outstanding instruction fetch sequencer.
// Fetches one word at a time and hands it to decode over valid/ready.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] curr_PC,
    output logic [31:0] curr_RA,
    input  logic [31:0] next_PC,
    input  logic [31:0] next_RA,
    input  logic        br_valid,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ra_q, ra_d;
    logic [31:0] buf_q, buf_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ra_d    = ra_q;
        buf_d   = buf_q;
        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    buf_d   = imem_rdata;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (id_ready) begin
                    state_d = S_REQ;
                    // Jump targets are forced word-aligned.
                    if (br_valid) begin
                        pc_d = next_PC & 32'hFFFF_FFFC;
                        ra_d = next_RA;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ra_q    <= 32'd0;
            buf_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ra_q    <= ra_d;
            buf_q   <= buf_d;
        end
    end

    assign imem_req  = (state_q == S_REQ);
    assign if_valid  = (state_q == S_HOLD);
    assign imem_addr = pc_q;
    assign curr_PC   = pc_q;
    assign curr_RA   = ra_q;
    assign if_pc     = pc_q;
    assign if_instr  = buf_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a simple one-word memory model.
// A second instance checks the RESET_PC wrap case in lockstep.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] curr_PC, curr_RA, next_PC, next_RA;
    logic        br_valid;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_valid, id_ready;
    logic [31:0] if_instr, if_pc;

    logic [31:0] w_pc, w_ra, w_addr, w_instr, w_ifpc;
    logic        w_req, w_valid;

    int errors = 0;
    int checks = 0;

    logic        gnt_en = 1'b1;
    logic        pend = 1'b0;
    logic [31:0] paddr = 32'd0;
    logic        ovr = 1'b0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .curr_PC    (curr_PC),
        .curr_RA    (curr_RA),
        .next_PC    (next_PC),
        .next_RA    (next_RA),
        .br_valid   (br_valid),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .id_ready   (id_ready)
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk        (clk),
        .rst_n      (rst_n),
        .curr_PC    (w_pc),
        .curr_RA    (w_ra),
        .next_PC    (next_PC),
        .next_RA    (next_RA),
        .br_valid   (br_valid),
        .imem_req   (w_req),
        .imem_addr  (w_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .if_valid   (w_valid),
        .if_instr   (w_instr),
        .if_pc      (w_ifpc),
        .id_ready   (id_ready)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mem_req();
        pend     = imem_req && gnt_en;
        paddr    = imem_addr;
        imem_gnt = pend;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        imem_rvalid = pend;
        imem_rdata  = pend ? (ovr ? 32'hDEAD_BEEF : word(paddr)) : 32'd0;
        mem_req();
    endtask

    // Enters in REQ for address a; leaves in HOLD.
    task automatic fetch(input logic [31:0] a);
        chk("req_hi", {31'd0, imem_req}, 32'd1);
        chk("req_addr", imem_addr, a);
        step();
        chk("wait_req", {31'd0, imem_req}, 32'd0);
        chk("wait_valid", {31'd0, if_valid}, 32'd0);
        step();
        chk("hold_valid", {31'd0, if_valid}, 32'd1);
        chk("hold_pc", if_pc, a);
        chk("hold_instr", if_instr, ovr ? 32'hDEAD_BEEF : word(a));
    endtask

    task automatic accept_br(input logic [31:0] npc, input logic [31:0] nra);
        br_valid = 1'b1;
        next_PC  = npc;
        next_RA  = nra;
        step();
        br_valid = 1'b0;
        next_PC  = 32'h0BAD_0000;
        next_RA  = 32'h0BAD_0001;
    endtask

    initial begin
        rst_n       = 1'b0;
        id_ready    = 1'b1;
        br_valid    = 1'b0;
        next_PC     = 32'h0BAD_0000;
        next_RA     = 32'h0BAD_0001;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        step();
        step();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_ifpc", if_pc, 32'd0);
        chk("rst_ra", curr_RA, 32'd0);
        chk("w_rst_addr", w_addr, 32'hFFFF_FFFC);

        rst_n = 1'b1;
        mem_req();
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        step();
        fetch(32'd0);
        step();
        chk("w_wrap_addr", w_addr, 32'd0);
        chk("w_wrap_req", {31'd0, w_req}, 32'd1);
        fetch(32'd4);
        step();
        fetch(32'd8);
        step();
        fetch(32'd12);
        accept_br(32'd4, 32'd0);
        chk("br4_addr", imem_addr, 32'd4);

        fetch(32'd4);
        accept_br(32'd24, 32'd12);
        chk("beq_t_addr", imem_addr, 32'd24);
        chk("beq_t_ra", curr_RA, 32'd12);
        fetch(32'd24);
        accept_br(32'd8, 32'd12);
        chk("beq_nt_addr", imem_addr, 32'd8);
        chk("beq_nt_ra", curr_RA, 32'd12);

        fetch(32'd8);
        accept_br(32'd4, 32'd12);
        fetch(32'd4);
        accept_br(32'd24, 32'd8);
        chk("jal_pc", curr_PC, 32'd24);
        chk("jal_ra", curr_RA, 32'd8);
        fetch(32'd24);
        gnt_en = 1'b0;
        accept_br(32'd27, 32'd8);
        chk("align_addr", imem_addr, 32'd24);

        // Grant stall with a stray branch request that must be ignored.
        br_valid = 1'b1;
        next_PC  = 32'h0000_0100;
        next_RA  = 32'h0000_0999;
        for (int i = 0; i < 5; i++) begin
            chk("stall_req", {31'd0, imem_req}, 32'd1);
            chk("stall_addr", imem_addr, 32'd24);
            if (i < 4) step();
        end
        gnt_en   = 1'b1;
        ovr      = 1'b1;
        id_ready = 1'b0;
        mem_req();
        fetch(32'd24);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_valid", {31'd0, if_valid}, 32'd1);
            chk("bp_instr", if_instr, 32'hDEAD_BEEF);
            chk("bp_req", {31'd0, imem_req}, 32'd0);
        end
        br_valid = 1'b0;
        id_ready = 1'b1;
        ovr      = 1'b0;
        step();
        chk("bp_next_addr", imem_addr, 32'd28);
        chk("bp_ra", curr_RA, 32'd8);

        step();
        chk("mid_wait_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b0;
        rst_n       = 1'b0;
        step();
        chk("mid_rst_valid", {31'd0, if_valid}, 32'd0);
        chk("mid_rst_addr", imem_addr, 32'd0);
        chk("mid_rst_instr", if_instr, 32'd0);
        chk("mid_rst_ra", curr_RA, 32'd0);
        rst_n       = 1'b1;
        mem_req();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        step();
        chk("stale_valid", {31'd0, if_valid}, 32'd0);
        chk("stale_instr", if_instr, 32'd0);
        fetch(32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter and instruction-fetch sequencer that sits on the far side of `Branch_Unit`. It owns the PC and return-address registers and drives them to the branch unit as `curr_PC`/`curr_RA`. It consumes the branch unit's `next_PC`/`next_RA` when decode accepts a resolved branch or jump. It fetches one instruction at a time from instruction memory over a req/gnt/rvalid handshake and presents it to decode over a valid/ready handshake.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded at reset; bits [1:0] must be 0.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `curr_PC`  out  32: PC register; to `Branch_Unit.curr_PC`.
- `curr_RA`  out  32: RA register; to `Branch_Unit.curr_RA`.
- `next_PC`  in  32: from `Branch_Unit.next_PC`.
- `next_RA`  in  32: from `Branch_Unit.next_RA`.
- `br_valid`  in  1: decode marks the instruction being accepted as a branch or jump; take `next_PC`/`next_RA`.
- `imem_req`  out  1: fetch request.
- `imem_addr`  out  32: fetch address; always equals `curr_PC`.
- `imem_gnt`  in  1: request accepted.
- `imem_rvalid`  in  1: read data valid; earliest one cycle after gnt.
- `imem_rdata`  in  32: instruction word.
- `if_valid`  out  1: instruction available to decode.
- `if_instr`  out  32: buffered instruction.
- `if_pc`  out  32: PC of `if_instr`; equals `curr_PC`.
- `id_ready`  in  1: decode accepts.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD. All outputs are registered or decoded from the current state.
- IDLE: `imem_req`=0, `if_valid`=0. Unconditionally goes to REQ next cycle.
- REQ: `imem_req`=1, `imem_addr`=pc. `imem_req` and `imem_addr` hold stable until `imem_gnt`. On gnt, go to WAIT.
- WAIT: `imem_req`=0. On `imem_rvalid`, latch `imem_rdata` into the instruction buffer and go to HOLD.
- HOLD: `if_valid`=1, `if_instr`=buffer. On `id_ready`, the instruction is accepted and the FSM goes to REQ.
- Accept with `br_valid`=0: pc <= pc + 4, mod 2^32 (32'hFFFF_FFFC wraps to 0). ra unchanged.
- Accept with `br_valid`=1: pc <= {`next_PC`[31:2], 2'b00}; ra <= `next_RA`.
- `br_valid` is ignored outside an accept (HOLD && `id_ready`). `next_PC`/`next_RA` are sampled only at accept.
- `imem_gnt` is ignored outside REQ. `imem_rvalid` is ignored outside WAIT; a stale response after reset is dropped.
- Only one request is outstanding at any time; there is no prefetch.

## Timing
- Reset state (any cycle with `rst_n`=0 at clk edge): state=IDLE, pc=`RESET_PC`, ra=0, buffer=0. Outputs: `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_instr`=0, `if_pc`=`RESET_PC`, `curr_RA`=0.
- First cycle after reset release is IDLE. `imem_req` rises on the second cycle.
- Best-case cadence, with gnt in the REQ cycle and rvalid the next cycle: REQ, WAIT, HOLD. That is one instruction per 3 cycles when `id_ready`=1.
- New pc/ra appear on `curr_PC`/`curr_RA` the cycle after accept, which is the same cycle REQ issues the new address.
- Backpressure: `if_valid` and `if_instr` hold stable for as long as `id_ready`=0.
- Reset mid-operation (REQ/WAIT/HOLD) aborts immediately. The buffered instruction is discarded and nothing is presented to decode until a fresh fetch completes.
- gnt and rvalid in the same cycle: rvalid is ignored because the FSM is in REQ. The memory must not do this.

## Test plan
- Reset, memory with gnt in the REQ cycle and rvalid one cycle later, `id_ready`=1, `br_valid`=0 → `imem_addr` 0, 4, 8 on successive REQ cycles. `if_pc`=0, 4, 8, with `if_valid` pulses 3 cycles apart.
- At `if_pc`=4, accept with `br_valid`=1, `next_PC`=24, `next_RA`=12 (beq taken) → next `imem_addr`=24, `curr_RA` stays 12. A second accept with `next_PC`=8 (beq not taken) → addr 8.
- Accept with `br_valid`=1, `next_PC`=24, `next_RA`=8 (jal, `curr_PC`=4) → `curr_RA`=8 and pc=24 the next cycle. `next_PC`=27 → pc=24 (low bits cleared).
- Hold `imem_gnt`=0 for 5 cycles, then `id_ready`=0 for 4 cycles in HOLD → `imem_req`/`imem_addr` stable throughout the gnt stall; `if_valid`/`if_instr`=32'hDEAD_BEEF stable throughout the backpressure.
- `RESET_PC`=32'hFFFF_FFFC, one sequential accept → next `imem_addr`=0.
- Assert `rst_n`=0 in WAIT, then have memory drive `imem_rvalid` in the IDLE cycle after release → response dropped, `if_valid` stays 0, and fetch restarts at `RESET_PC`.
